// File: rtl/uart_bus_bridge.sv
// UART (8N1) debug/loader bridge acting as a second bus initiator.
// Host frames: 'W' a0..a3 d0..d3 or 'R' a0..a3; replies ACK/NAK, plus read data on success.
module uart_bus_bridge #(
   parameter logic [15:0] DIV          = 16'd1458,
   parameter int unsigned BYTE_TIMEOUT = 20,
   parameter int unsigned BUS_TIMEOUT  = 255
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        RX,
   output logic        TX,
   output logic        bus_req,
   output logic        bus_we,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   input  logic        bus_err,
   output logic        busy
);
   localparam logic [7:0]  CMD_W       = 8'h57;
   localparam logic [7:0]  CMD_R       = 8'h52;
   localparam logic [7:0]  ACK         = 8'h06;
   localparam logic [7:0]  NAK         = 8'h15;
   localparam logic [15:0] DIV_LD      = DIV - 16'd1;
   localparam logic [15:0] HALF_LD     = (DIV >> 1) - 16'd1;
   localparam logic [31:0] BYTE_TMO_LD = 32'(BYTE_TIMEOUT) * 32'(DIV) - 32'd1;
   localparam logic [31:0] BUS_TMO_LD  = 32'(BUS_TIMEOUT) - 32'd1;
   localparam logic [42:0] NAK_RESP    = {3'd1, 32'd0, NAK};

   // ------------------------------------------------------------------ RX
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t   rx_state_q;
   logic        rx_s1_q, rx_s2_q, rx_prev_q;
   logic [15:0] rx_cnt_q;
   logic [2:0]  rx_bit_q;
   logic [7:0]  rx_sh_q;
   logic        rx_valid_q, rx_ferr_q;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         rx_s1_q    <= RX;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               if (rx_prev_q && !rx_s2_q) begin
                  rx_state_q <= RX_START;
                  rx_cnt_q   <= HALF_LD;
               end
            end
            RX_START: begin
               if (rx_cnt_q == '0) begin
                  rx_cnt_q   <= DIV_LD;
                  rx_bit_q   <= '0;
                  rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_q <= rx_cnt_q - 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt_q == '0) begin
                  rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                  rx_cnt_q <= DIV_LD;
                  rx_bit_q <= rx_bit_q + 3'd1;
                  if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
               end else begin
                  rx_cnt_q <= rx_cnt_q - 16'd1;
               end
            end
            RX_STOP: begin
               if (rx_cnt_q == '0) begin
                  rx_valid_q <= rx_s2_q;
                  rx_ferr_q  <= !rx_s2_q;
                  rx_state_q <= RX_IDLE;
               end else begin
                  rx_cnt_q <= rx_cnt_q - 16'd1;
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------ TX
   logic        tx_q, tx_busy_q, tx_start_q;
   logic [8:0]  tx_sh_q;
   logic [15:0] tx_cnt_q;
   logic [3:0]  tx_bit_q;
   logic [39:0] resp_q;
   logic        tx_done, tx_accept;

   // Accepting on the last stop cycle lets queued bytes go out with no idle gap.
   assign tx_done   = tx_busy_q && (tx_cnt_q == '0) && (tx_bit_q == 4'd9);
   assign tx_accept = tx_start_q && (!tx_busy_q || tx_done);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         tx_q      <= 1'b1;
         tx_busy_q <= 1'b0;
         tx_sh_q   <= '1;
         tx_cnt_q  <= '0;
         tx_bit_q  <= '0;
      end else if (tx_accept) begin
         tx_q      <= 1'b0;
         tx_busy_q <= 1'b1;
         tx_sh_q   <= {1'b1, resp_q[7:0]};
         tx_cnt_q  <= DIV_LD;
         tx_bit_q  <= '0;
      end else if (tx_busy_q) begin
         if (tx_cnt_q == '0) begin
            if (tx_bit_q == 4'd9) begin
               tx_busy_q <= 1'b0;
            end else begin
               tx_q     <= tx_sh_q[0];
               tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
               tx_bit_q <= tx_bit_q + 4'd1;
               tx_cnt_q <= DIV_LD;
            end
         end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
         end
      end
   end

   // ------------------------------------------------------------------ command FSM
   // state      | meaning
   // C_IDLE     | wait for 'W'/'R' command byte
   // C_ADDR     | collect 4 address bytes, LSB first
   // C_DATA     | collect 4 write-data bytes, LSB first
   // C_BUS_REQ  | bus_req high until gnt or bus timeout
   // C_BUS_RESP | wait for rvalid or bus timeout
   // C_RESP     | hand queued response bytes to TX
   // C_DRAIN    | wait for the last stop bit, then release busy
   typedef enum logic [2:0] {
      C_IDLE, C_ADDR, C_DATA, C_BUS_REQ, C_BUS_RESP, C_RESP, C_DRAIN
   } cmd_state_t;

   cmd_state_t  st_q;
   logic [1:0]  byte_cnt_q;
   logic [31:0] tmr_q;
   logic [2:0]  resp_left_q;
   logic        busy_q, bus_req_q, bus_we_q;
   logic [3:0]  bus_be_q;
   logic [31:0] bus_addr_q, bus_wdata_q;

   function automatic logic [42:0] mk_resp(input logic we, input logic err,
                                           input logic [31:0] rdata);
      if (err)     return NAK_RESP;
      else if (we) return {3'd1, 32'd0, ACK};
      else         return {3'd5, rdata, ACK};
   endfunction

   always_ff @(posedge Clk) begin
      if (Rst) begin
         st_q        <= C_IDLE;
         byte_cnt_q  <= '0;
         tmr_q       <= '0;
         resp_q      <= '0;
         resp_left_q <= '0;
         tx_start_q  <= 1'b0;
         busy_q      <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_be_q    <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
      end else begin
         case (st_q)
            C_IDLE: begin
               if (rx_valid_q) begin
                  busy_q     <= 1'b1;
                  byte_cnt_q <= '0;
                  tmr_q      <= BYTE_TMO_LD;
                  if (rx_sh_q == CMD_W || rx_sh_q == CMD_R) begin
                     bus_we_q <= (rx_sh_q == CMD_W);
                     st_q     <= C_ADDR;
                  end else begin
                     {resp_left_q, resp_q} <= NAK_RESP;
                     tx_start_q            <= 1'b1;
                     st_q                  <= C_RESP;
                  end
               end
            end
            C_ADDR, C_DATA: begin
               if (rx_ferr_q) begin
                  {resp_left_q, resp_q} <= NAK_RESP;
                  tx_start_q            <= 1'b1;
                  st_q                  <= C_RESP;
               end else if (rx_valid_q) begin
                  tmr_q      <= BYTE_TMO_LD;
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (st_q == C_ADDR)
                     bus_addr_q <= {rx_sh_q, bus_addr_q[31:8]} & 32'hFFFF_FFFC;
                  else
                     bus_wdata_q <= {rx_sh_q, bus_wdata_q[31:8]};
                  if (byte_cnt_q == 2'd3) begin
                     if (st_q == C_ADDR && bus_we_q) begin
                        st_q <= C_DATA;
                     end else begin
                        st_q      <= C_BUS_REQ;
                        bus_req_q <= 1'b1;
                        bus_be_q  <= 4'hF;
                        tmr_q     <= BUS_TMO_LD;
                     end
                  end
               end else if (tmr_q == '0) begin
                  st_q   <= C_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  tmr_q <= tmr_q - 32'd1;
               end
            end
            C_BUS_REQ: begin
               if (bus_gnt) begin
                  bus_req_q <= 1'b0;
                  bus_be_q  <= '0;
                  if (bus_rvalid) begin
                     {resp_left_q, resp_q} <= mk_resp(bus_we_q, bus_err, bus_rdata);
                     tx_start_q            <= 1'b1;
                     st_q                  <= C_RESP;
                  end else begin
                     tmr_q <= BUS_TMO_LD;
                     st_q  <= C_BUS_RESP;
                  end
               end else if (tmr_q == '0) begin
                  bus_req_q             <= 1'b0;
                  bus_be_q              <= '0;
                  {resp_left_q, resp_q} <= NAK_RESP;
                  tx_start_q            <= 1'b1;
                  st_q                  <= C_RESP;
               end else begin
                  tmr_q <= tmr_q - 32'd1;
               end
            end
            C_BUS_RESP: begin
               if (bus_rvalid) begin
                  {resp_left_q, resp_q} <= mk_resp(bus_we_q, bus_err, bus_rdata);
                  tx_start_q            <= 1'b1;
                  st_q                  <= C_RESP;
               end else if (tmr_q == '0) begin
                  {resp_left_q, resp_q} <= NAK_RESP;
                  tx_start_q            <= 1'b1;
                  st_q                  <= C_RESP;
               end else begin
                  tmr_q <= tmr_q - 32'd1;
               end
            end
            C_RESP: begin
               if (tx_accept) begin
                  resp_q      <= {8'h00, resp_q[39:8]};
                  resp_left_q <= resp_left_q - 3'd1;
                  if (resp_left_q == 3'd1) begin
                     tx_start_q <= 1'b0;
                     st_q       <= C_DRAIN;
                  end
               end
            end
            C_DRAIN: begin
               if (tx_done) begin
                  busy_q <= 1'b0;
                  st_q   <= C_IDLE;
               end
            end
            default: st_q <= C_IDLE;
         endcase
      end
   end

   assign TX        = tx_q;
   assign busy      = busy_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_be    = bus_be_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Debug/loader bridge. Receives 8N1 command frames on a UART line and issues single-word transactions as a bus initiator on the CPU data bus.
- Returns responses on its own TX line.
- Sits beside the core as a second bus master, used for memory load and peek/poke from a host PC.
- Single clock domain; the baud timing is derived from Clk.

Parameters:
- DIV, 16'd1458, Clk cycles per UART bit (Clk/baud); minimum 4.
- BYTE_TIMEOUT, 20, bit times allowed between bytes of one frame before the frame is abandoned.
- BUS_TIMEOUT, 255, Clk cycles allowed to wait for bus_gnt or for bus_rvalid.

Ports:
- Clk  in  1  system clock
- Rst  in  1  synchronous active-high reset
- RX  in  1  serial input, idle high, asynchronous to Clk
- TX  out  1  serial output, idle high
- bus_req  out  1  transaction request
- bus_we  out  1  1=write, 0=read
- bus_be  out  4  byte enables, always 4'b1111 while bus_req=1
- bus_addr  out  32  word address, bits [1:0] driven 0
- bus_wdata  out  32  write data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response valid
- bus_rdata  in  32  read data, valid with bus_rvalid
- bus_err  in  1  error, valid with bus_rvalid
- busy  out  1  high from command byte accepted to last response bit sent

Behaviour:
- Reset values: TX=1, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, busy=0. All FSMs go to idle.
- Reset mid-frame or mid-transaction aborts with no response. A held bus_gnt or bus_rvalid is ignored after reset.

RX deserializer:
- RX passes through a 2-flop synchroniser.
- Start is detected on a synchronised falling edge. The line is re-checked at DIV/2; if it is high, the start is false and RX returns to idle.
- Data bits are sampled every DIV, LSB first, then the stop bit.
- Stop=0 is a framing error: the byte is discarded and rx_ferr pulses for 1 cycle.
- A good byte gives rx_valid for 1 cycle. There is no buffering; a byte arriving while the command FSM cannot take it is dropped.

TX serializer:
- Accepts a byte when tx_start is asserted and it is idle.
- Sends start, 8 data bits LSB first, and 1 stop bit, each DIV cycles.
- tx_done pulses for 1 cycle at the end of the stop bit.

Command FSM states: IDLE, ADDR, DATA, BUS_REQ, BUS_RESP, RESP, DRAIN.
- IDLE:
  - 0x57 ('W') sets we=1, go to ADDR.
  - 0x52 ('R') sets we=0, go to ADDR.
  - Any other byte sends NAK 0x15, go to RESP.
  - busy=1 from the accepting cycle.
- ADDR: collects 4 bytes LSB first into the address register. Write goes to DATA; read goes to BUS_REQ.
- DATA: collects 4 bytes LSB first into wdata, then goes to BUS_REQ.
- BUS_REQ:
  - Drives bus_req=1 with stable addr/we/be/wdata until bus_gnt=1 is sampled.
  - bus_req drops the cycle after the gnt cycle, then go to BUS_RESP.
- BUS_RESP:
  - Waits for bus_rvalid. bus_rvalid in the same cycle as gnt is accepted.
  - Write: err=0 sends ACK 0x06; err=1 sends NAK.
  - Read: err=0 sends ACK followed by rdata bytes [7:0],[15:8],[23:16],[31:24] (5 bytes); err=1 sends NAK only.
- RESP: sends the queued bytes back-to-back, with start following stop directly. Then go to IDLE with busy=0.
- Bytes received during BUS_REQ, BUS_RESP or RESP are ignored.

Timeouts and errors:
- Byte timeout: in ADDR or DATA, if no rx_valid arrives within BYTE_TIMEOUT*DIV cycles, go to IDLE silently.
- Bus timeout: a counter clears on state entry. Reaching BUS_TIMEOUT in BUS_REQ or BUS_RESP drops bus_req and sends NAK.
- rx_ferr in ADDR or DATA sends NAK and goes to RESP. In IDLE it is ignored.
- Address bits [1:0] received from the host are discarded.
- All counters are wide enough for BYTE_TIMEOUT*DIV with no wrap.

Test Plan:
- DIV=8. Host sends 57 00 10 00 00 EF BE AD DE, gnt/rvalid given 2 cycles after req → one bus write with addr=0x00001000, wdata=0xDEADBEEF, be=F; TX returns 06.
- Read 52 04 20 00 00, slave rvalid with rdata=0x12345678 → addr=0x00002004; TX returns 06 78 56 34 12; busy falls after the last stop bit.
- Read with bus_err=1 → TX returns 15 only; bus_req held exactly until the gnt cycle.
- Unknown byte 0x41 → immediate 15, no bus activity. Stop-bit=0 inside the address bytes → 15.
- Send 57 00 then silence for more than 20 bit times → no TX activity and no bus_req; next 52 frame works normally.
- bus_gnt tied low → bus_req held for 255 cycles, then dropped and 15 sent. Rst asserted mid-frame → TX=1, bus_req=0 the next cycle; subsequent frame works.
